// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the sizing helper for the iteration counter.
package seq_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Counter must hold WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor with a ripple borrow chain, keep the difference if it did not borrow.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   borrow;

    assign shifted = {rem[WIDTH-2:0], bit_in};

    always_comb begin
        borrow    = '0;
        diff      = '0;
        borrow[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i]       = shifted[i] ^ divisor[i] ^ borrow[i];
            borrow[i + 1] = (~shifted[i] & divisor[i]) |
                            (~(shifted[i] ^ divisor[i]) & borrow[i]);
        end
    end

    // Bit WIDTH of the (WIDTH+1)-bit trial is rem's old MSB minus zero; the
    // trial is non-negative when that bit absorbs or never sees a borrow.
    assign q_bit    = rem[WIDTH-1] | ~borrow[WIDTH];
    assign rem_next = q_bit ? diff : shifted;

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock, MSB first.
// Holds the control FSM, iteration counter and result registers.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = cnt_width(WIDTH);

    // Handshake: start is accepted on a rising edge only in IDLE with done low;
    // busy rises from that edge and falls on the edge that raises done, which
    // pulses for one cycle. Results and div_by_zero then hold until the next
    // accepted start.
    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] dsr_q;
    logic             dz_q;
    logic             accept;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    assign accept    = (state == S_IDLE) && start && !done;
    assign dbg_state = state;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .divisor  (dsr_q),
        .bit_in   (q_sh[WIDTH-1]),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            S_IDLE: if (accept) state_nx = (divisor == '0) ? S_FIN : S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (count == '0) state_nx = S_FIN;
            end
            S_FIN: begin
                busy     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // q_sh starts as the dividend and fills with quotient bits as it shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            rem_q       <= '0;
            q_sh        <= '0;
            dsr_q       <= '0;
            dz_q        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        q_sh        <= dividend;
                        dsr_q       <= divisor;
                        rem_q       <= '0;
                        count       <= CW'(WIDTH - 1);
                        dz_q        <= (divisor == '0);
                        div_by_zero <= 1'b0;
                    end
                end
                S_RUN: begin
                    rem_q <= rem_next;
                    q_sh  <= {q_sh[WIDTH-2:0], q_bit};
                    count <= count - 1'b1;
                end
                S_FIN: begin
                    done        <= 1'b1;
                    div_by_zero <= dz_q;
                    if (dz_q) begin
                        quotient  <= '1;
                        remainder <= q_sh;
                    end else begin
                        quotient  <= q_sh;
                        remainder <= rem_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
